// File: rtl/adc_frame_capture_if.sv
// Frame capture bus: ADC slice frames and capture control in, readout and capture status out.
// Latency: none (wiring only). Backpressure: none; frames are pulse-qualified by frame_valid.
interface adc_frame_capture_if #(
    parameter int NTI    = 16,
    parameter int NADC   = 8,
    parameter int ADDR_W = 6
);
    logic                       frame_valid;
    logic [NTI-1:0]             sign_in;
    logic [NADC-1:0]            mag_in [NTI];
    logic                       arm;
    logic                       trigger;
    logic [ADDR_W:0]            post_len;
    logic                       rd_en;
    logic [ADDR_W-1:0]          rd_addr;
    logic [NTI*(NADC+1)-1:0]    rd_data;
    logic                       rd_valid;
    logic [1:0]                 state;
    logic                       done;
    logic [ADDR_W-1:0]          trig_addr;
    logic                       pre_full;

    modport slave (
        input  frame_valid, sign_in, mag_in, arm, trigger, post_len, rd_en, rd_addr,
        output rd_data, rd_valid, state, done, trig_addr, pre_full
    );

    modport master (
        output frame_valid, sign_in, mag_in, arm, trigger, post_len, rd_en, rd_addr,
        input  rd_data, rd_valid, state, done, trig_addr, pre_full
    );
endinterface

// File: rtl/adc_frame_capture.sv
// Converts sign/magnitude slice frames to two's complement and captures them in a circular buffer around a trigger.
// Latency: frame written on the strobe edge; readout 1 cycle from rd_en. Backpressure: none, frames outside a capture are dropped.
// Buffer reads are read-first and allowed in any state.
module adc_frame_capture #(
    parameter int NTI    = 16,
    parameter int NADC   = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                     emu_clk,
    input  logic                     emu_rst,
    adc_frame_capture_if.slave       bus
);
    localparam int W  = NADC + 1;
    localparam int FW = NTI * W;
    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    state_t             state;
    logic               done;
    logic [ADDR_W-1:0]  trig_addr;
    logic               pre_full;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [CW-1:0]      fill_cnt;
    logic [CW-1:0]      post_cnt;
    logic [CW-1:0]      eff_post;
    logic               trig_pend;

    logic [FW-1:0]      mem [DEPTH];
    logic [FW-1:0]      frame_cv;
    logic [W-1:0]       ext;
    logic [CW-1:0]      eff_len;
    logic               wr_en;
    logic               trig_hit;

    always_comb begin
        frame_cv = '0;
        ext      = '0;
        for (int k = 0; k < NTI; k++) begin
            ext = {1'b0, bus.mag_in[k]};
            frame_cv[k*W +: W] = bus.sign_in[k] ? ext : (~ext + W'(1));
        end
    end

    // Post-trigger length clamped to 1..DEPTH
    always_comb begin
        if (bus.post_len == '0)
            eff_len = CW'(1);
        else if (bus.post_len > CW'(DEPTH))
            eff_len = CW'(DEPTH);
        else
            eff_len = bus.post_len;
    end

    assign wr_en    = bus.frame_valid && !bus.arm && (state == ARMED || state == POST);
    assign trig_hit = (state == ARMED) && (trig_pend || bus.trigger);

    always_ff @(posedge emu_clk) begin
        if (wr_en)
            mem[wr_ptr] <= frame_cv;
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            trig_addr <= '0;
            pre_full  <= 1'b0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            eff_post  <= CW'(1);
            trig_pend <= 1'b0;
        end else if (bus.arm) begin
            // Arm from any state restarts the capture and drops any pending trigger.
            state     <= ARMED;
            done      <= 1'b0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            trig_pend <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (fill_cnt != CW'(DEPTH))
                    fill_cnt <= fill_cnt + CW'(1);
            end
            case (state)
                ARMED: begin
                    if (wr_en && trig_hit) begin
                        trig_addr <= wr_ptr;
                        post_cnt  <= CW'(1);
                        eff_post  <= eff_len;
                        pre_full  <= (fill_cnt >= (CW'(DEPTH) - eff_len));
                        trig_pend <= 1'b0;
                        if (eff_len == CW'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= POST;
                        end
                    end else if (bus.trigger) begin
                        trig_pend <= 1'b1;
                    end
                end
                POST: begin
                    if (wr_en) begin
                        post_cnt <= post_cnt + CW'(1);
                        if (post_cnt + CW'(1) == eff_post) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en)
                bus.rd_data <= mem[bus.rd_addr];
        end
    end

    assign bus.state     = state;
    assign bus.done      = done;
    assign bus.trig_addr = trig_addr;
    assign bus.pre_full  = pre_full;
endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture: table-driven conversion vectors plus capture sequences, reads checked via a scoreboard queue.
module tb_adc_frame_capture;
    localparam int NTI   = 16;
    localparam int NADC  = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int W     = NADC + 1;
    localparam int FW    = NTI * W;

    typedef struct {
        logic           sgn;
        logic [7:0]     mag;
        logic [8:0]     exp;
    } vec_t;

    logic emu_clk = 1'b0;
    logic emu_rst;
    always #5 emu_clk = ~emu_clk;

    adc_frame_capture_if #(.NTI(NTI), .NADC(NADC), .ADDR_W(AW)) bus ();

    adc_frame_capture #(.NTI(NTI), .NADC(NADC), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .emu_clk (emu_clk),
        .emu_rst (emu_rst),
        .bus     (bus)
    );

    int             n_cmp  = 0;
    int             n_fail = 0;
    logic [FW-1:0]  model [DEPTH];
    int             m_wr   = 0;
    logic [FW-1:0]  exp_q [$];
    logic [FW-1:0]  mon_exp;
    vec_t           tbl [8];

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge emu_clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid high with no read outstanding at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", bus.rd_data, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge emu_clk);
        #1;
    endtask

    function automatic logic [FW-1:0] ramp_word(input int f);
        logic [FW-1:0] w;
        logic [7:0]    m;
        w = '0;
        for (int k = 0; k < NTI; k++) begin
            m = 8'(k + f);
            w[k*W +: W] = {1'b0, m};
        end
        return w;
    endfunction

    task automatic drive_frame(input logic [NTI*NADC-1:0] mags, input logic [NTI-1:0] signs,
                               input logic trig, input logic wr, input logic [FW-1:0] expw);
        for (int k = 0; k < NTI; k++)
            bus.mag_in[k] = mags[k*NADC +: NADC];
        bus.sign_in     = signs;
        bus.frame_valid = 1'b1;
        bus.trigger     = trig;
        tick();
        bus.frame_valid = 1'b0;
        bus.trigger     = 1'b0;
        if (wr) begin
            model[m_wr] = expw;
            m_wr = (m_wr + 1) % DEPTH;
        end
    endtask

    task automatic send_ramp(input int f, input logic trig, input logic wr);
        logic [NTI*NADC-1:0] mags;
        for (int k = 0; k < NTI; k++)
            mags[k*NADC +: NADC] = 8'(k + f);
        drive_frame(mags, '1, trig, wr, ramp_word(f));
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        m_wr = 0;
    endtask

    task automatic pulse_trigger();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
    endtask

    task automatic do_read(input int addr);
        exp_q.push_back(model[addr]);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        tick();
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        logic [NTI*NADC-1:0] mags;
        logic [NTI-1:0]      signs;
        logic [FW-1:0]       expw;

        bus.frame_valid = 1'b0;
        bus.sign_in     = '0;
        for (int k = 0; k < NTI; k++) bus.mag_in[k] = '0;
        bus.arm      = 1'b0;
        bus.trigger  = 1'b0;
        bus.post_len = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        emu_rst      = 1'b1;
        tick();
        tick();
        emu_rst = 1'b0;

        check("rst_state", bus.state, 2'd0);
        check("rst_done", bus.done, 1'b0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_data", bus.rd_data, '0);
        check("rst_trig_addr", bus.trig_addr, '0);
        check("rst_pre_full", bus.pre_full, 1'b0);

        // Basic capture: trigger on frame 4, three post frames
        bus.post_len = 7'd3;
        do_arm();
        check("t1_armed", bus.state, 2'd1);
        for (int f = 0; f < 10; f++) begin
            send_ramp(f, f == 4, f <= 6);
            if (f == 4) begin
                check("t1_post", bus.state, 2'd2);
                check("t1_trig_addr", bus.trig_addr, 6'd4);
            end
            if (f == 5) check("t1_not_done", bus.done, 1'b0);
            if (f == 6) check("t1_done", bus.done, 1'b1);
        end
        check("t1_state_hold", bus.state, 2'd3);
        check("t1_trig_addr_hold", bus.trig_addr, 6'd4);
        check("t1_pre_full", bus.pre_full, 1'b0);
        for (int a = 0; a <= 6; a++) do_read(a);

        // Conversion vectors, rotated across slices frame by frame
        tbl[0] = '{1'b0, 8'hFF, 9'h101};
        tbl[1] = '{1'b0, 8'h00, 9'h000};
        tbl[2] = '{1'b1, 8'h80, 9'h080};
        tbl[3] = '{1'b1, 8'h00, 9'h000};
        tbl[4] = '{1'b0, 8'h01, 9'h1FF};
        tbl[5] = '{1'b1, 8'hFF, 9'h0FF};
        tbl[6] = '{1'b0, 8'h80, 9'h180};
        tbl[7] = '{1'b1, 8'h7F, 9'h07F};
        bus.post_len = 7'd8;
        do_arm();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NTI; k++) begin
                signs[k]                 = tbl[(i + k) % 8].sgn;
                mags[k*NADC +: NADC]     = tbl[(i + k) % 8].mag;
                expw[k*W +: W]           = tbl[(i + k) % 8].exp;
            end
            drive_frame(mags, signs, i == 0, 1'b1, expw);
        end
        check("t2_done", bus.state, 2'd3);
        check("t2_trig_addr", bus.trig_addr, 6'd0);
        for (int a = 0; a < 8; a++) do_read(a);

        // Long pre-trigger history wraps the buffer
        bus.post_len = 7'd8;
        do_arm();
        for (int f = 0; f < 108; f++) begin
            send_ramp(f, f == 100, 1'b1);
            if (f == 99)  check("t3_still_armed", bus.state, 2'd1);
            if (f == 106) check("t3_post", bus.state, 2'd2);
        end
        check("t3_done", bus.state, 2'd3);
        check("t3_trig_addr", bus.trig_addr, 6'd36);
        check("t3_pre_full", bus.pre_full, 1'b1);
        do_read(36);
        do_read(43);
        do_read(44);
        do_read(0);
        do_read(63);

        // Arm beats trigger; pending trigger picks up the next frame; post_len sampled once
        bus.post_len = 7'd2;
        bus.arm      = 1'b1;
        bus.trigger  = 1'b1;
        tick();
        bus.arm      = 1'b0;
        bus.trigger  = 1'b0;
        m_wr = 0;
        check("t4_arm_wins", bus.state, 2'd1);
        send_ramp(200, 1'b0, 1'b1);
        check("t4_no_trigger", bus.state, 2'd1);
        pulse_trigger();
        repeat (2) tick();
        pulse_trigger();
        repeat (2) tick();
        check("t4_pending_armed", bus.state, 2'd1);
        send_ramp(201, 1'b0, 1'b1);
        check("t4_post", bus.state, 2'd2);
        check("t4_trig_addr", bus.trig_addr, 6'd1);
        bus.post_len = 7'd10;
        send_ramp(202, 1'b0, 1'b1);
        check("t4_done", bus.state, 2'd3);
        pulse_trigger();
        check("t4_trig_in_done", bus.state, 2'd3);
        do_read(0);
        do_read(1);
        do_read(2);

        // post_len clamping
        bus.post_len = 7'd0;
        do_arm();
        send_ramp(300, 1'b1, 1'b1);
        check("t5_len0_done", bus.done, 1'b1);
        check("t5_len0_trig_addr", bus.trig_addr, 6'd0);
        check("t5_len0_pre_full", bus.pre_full, 1'b0);
        bus.post_len = 7'd127;
        do_arm();
        for (int f = 0; f < 64; f++) begin
            send_ramp(400 + f, f == 0, 1'b1);
            if (f == 62) check("t5_len127_post", bus.state, 2'd2);
        end
        check("t5_len127_done", bus.state, 2'd3);
        check("t5_len127_pre_full", bus.pre_full, 1'b1);
        send_ramp(500, 1'b0, 1'b0);
        do_read(0);
        do_read(63);

        // Reset during POST, then read-first on a same-address collision
        bus.post_len = 7'd5;
        do_arm();
        send_ramp(600, 1'b1, 1'b1);
        check("t6_post", bus.state, 2'd2);
        emu_rst     = 1'b1;
        bus.rd_en   = 1'b1;
        bus.rd_addr = '0;
        tick();
        emu_rst   = 1'b0;
        bus.rd_en = 1'b0;
        check("t6_rst_state", bus.state, 2'd0);
        check("t6_rst_done", bus.done, 1'b0);
        check("t6_rst_rd_valid", bus.rd_valid, 1'b0);
        check("t6_rst_rd_data", bus.rd_data, '0);
        pulse_trigger();
        check("t6_trig_in_idle", bus.state, 2'd0);
        do_arm();
        check("t6_armed", bus.state, 2'd1);
        exp_q.push_back(model[0]);
        bus.rd_en   = 1'b1;
        bus.rd_addr = '0;
        send_ramp(700, 1'b0, 1'b1);
        bus.rd_en   = 1'b0;
        do_read(0);

        repeat (3) tick();
        check("scoreboard_drained", FW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
